// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: merges in-order writeback (port A) with a small FIFO of
// late multicycle results (port B) into one registered write per cycle.
module wb_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4,
  parameter int QDEPTH       = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_valid,
  output logic                      a_ready,
  input  logic [ADDR_W-1:0]         a_rd,
  input  logic [DATA_W-1:0]         a_data,
  input  logic                      b_valid,
  output logic                      b_ready,
  input  logic [ADDR_W-1:0]         b_rd,
  input  logic [DATA_W-1:0]         b_data,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [2**ADDR_W-1:0]      pend_mask,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SW    = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(QDEPTH);
  localparam logic [SW-1:0]    STARVE_MAX = SW'(STARVE_LIMIT);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [QDEPTH-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0] mem_rd_q   [QDEPTH];
  logic [ADDR_W-1:0] mem_rd_d   [QDEPTH];
  logic [DATA_W-1:0] mem_data_q [QDEPTH];
  logic [DATA_W-1:0] mem_data_d [QDEPTH];
  logic [SW-1:0]     starve_q, starve_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic head_present;
  logic force_b;
  logic grant_a;
  logic grant_b;
  logic enq;

  // A queued write to the same register as the incoming A write must land first.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      if (valid_q[i]) begin
        pend_mask[mem_rd_q[i]] = 1'b1;
      end
    end
  end

  always_comb begin
    head_present = (count_q != '0);
    force_b      = head_present &&
                   ((starve_q == STARVE_MAX) || (a_valid && pend_mask[a_rd]));
    grant_a      = a_valid && !force_b;
    grant_b      = head_present && !grant_a;
    enq          = b_valid && (count_q != FULL_CNT);
  end

  assign a_ready  = grant_a;
  assign b_ready  = (count_q != FULL_CNT);
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign q_count  = count_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    valid_d    = valid_q;
    mem_rd_d   = mem_rd_q;
    mem_data_d = mem_data_q;
    if (grant_b) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end
    if (enq) begin
      valid_d[wr_ptr_q]    = 1'b1;
      mem_rd_d[wr_ptr_q]   = b_rd;
      mem_data_d[wr_ptr_q] = b_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (enq && !grant_b) begin
      count_d = count_q + CNT_W'(1);
    end else if (!enq && grant_b) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!head_present || grant_b) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end
  end

  // Address/data hold their last value when idle; only the enable drops.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_a) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = a_rd;
      rf_wdata_d = a_data;
    end else if (grant_b) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = mem_rd_q[rd_ptr_q];
      rf_wdata_d = mem_data_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        mem_rd_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      mem_rd_q   <= mem_rd_d;
      mem_data_q <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic, all
// compared against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int QD = 4;
  localparam int SL = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_ready, b_valid, b_ready, rf_we;
  logic [AW-1:0] a_rd, b_rd, rf_waddr;
  logic [DW-1:0] a_data, b_data, rf_wdata;
  logic [15:0]   pend_mask;
  logic [2:0]    q_count;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DATA_W(DW), .ADDR_W(AW), .QDEPTH(QD), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .q_count(q_count)
  );

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } entry_t;

  // Reference model: the FIFO as a queue, starvation as a plain integer.
  entry_t        mq[$];
  int            m_starve;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  int checks = 0;
  int errors = 0;

  // DUT outputs captured at the most recent mid-cycle sample, for directed checks.
  logic          last_a_ready, last_b_ready, last_rf_we;
  logic [AW-1:0] last_waddr;
  logic [DW-1:0] last_wdata;
  logic [15:0]   last_pend;
  logic [2:0]    last_q_count;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    m_starve = 0;
    m_we     = 1'b0;
    m_waddr  = '0;
    m_wdata  = '0;
  endtask

  // Drives one cycle: inputs applied just after a rising edge, outputs checked on the
  // falling edge, model advanced across the next rising edge.
  task automatic applyStimulus(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] adata,
                               input logic bv, input logic [AW-1:0] brd, input logic [DW-1:0] bdata);
    logic [15:0] pm;
    bit          head, force_b, ga, gb, br;
    entry_t      e;
    a_valid = av; a_rd = ard; a_data = adata;
    b_valid = bv; b_rd = brd; b_data = bdata;
    @(negedge clk);
    pm = '0;
    foreach (mq[i]) pm[mq[i].rd] = 1'b1;
    head    = (mq.size() != 0);
    force_b = head && ((m_starve == SL) || (av && pm[ard]));
    ga      = av && !force_b;
    gb      = head && !ga;
    br      = (mq.size() < QD);
    checkOutput("a_ready", a_ready, ga);
    checkOutput("b_ready", b_ready, br);
    checkOutput("q_count", q_count, mq.size());
    checkOutput("pend_mask", pend_mask, pm);
    checkOutput("rf_we", rf_we, m_we);
    checkOutput("rf_waddr", rf_waddr, m_waddr);
    checkOutput("rf_wdata", rf_wdata, m_wdata);
    last_a_ready = a_ready; last_b_ready = b_ready; last_rf_we = rf_we;
    last_waddr = rf_waddr; last_wdata = rf_wdata; last_pend = pend_mask; last_q_count = q_count;
    @(posedge clk);
    if (ga) begin
      m_we = 1'b1; m_waddr = ard; m_wdata = adata;
    end else if (gb) begin
      e = mq.pop_front();
      m_we = 1'b1; m_waddr = e.rd; m_wdata = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (!head || gb) m_starve = 0;
    else if (m_starve < SL) m_starve++;
    if (bv && br) mq.push_back({brd, bdata});
    #1;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    // Power-on reset: outputs must be cleared before any clock edge arrives.
    rst_n = 1'b0;
    a_valid = 1'b0; a_rd = '0; a_data = '0;
    b_valid = 1'b0; b_rd = '0; b_data = '0;
    modelReset();
    #2;
    checkOutput("rst_rf_we", rf_we, 1'b0);
    checkOutput("rst_q_count", q_count, 3'd0);
    checkOutput("rst_pend", pend_mask, 16'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // A only: one-cycle latency, enable drops afterwards.
    applyStimulus(1'b1, 4'd3, 32'h11, 1'b0, '0, '0);
    checkOutput("aonly_ready", last_a_ready, 1'b1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("aonly_we", last_rf_we, 1'b1);
    checkOutput("aonly_waddr", last_waddr, 4'd3);
    checkOutput("aonly_wdata", last_wdata, 32'h11);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("aonly_we_off", last_rf_we, 1'b0);

    // B only: enqueue edge, then head grant edge.
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd5, 32'hAA);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("bonly_qcnt1", last_q_count, 3'd1);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("bonly_we", last_rf_we, 1'b1);
    checkOutput("bonly_waddr", last_waddr, 4'd5);
    checkOutput("bonly_wdata", last_wdata, 32'hAA);
    checkOutput("bonly_qcnt0", last_q_count, 3'd0);

    // Starvation: A wins three times, the head is forced on the fourth, A resumes.
    applyStimulus(1'b1, 4'd1, 32'h1, 1'b1, 4'd2, 32'h22);
    applyStimulus(1'b1, 4'd1, 32'h2, 1'b0, '0, '0);
    checkOutput("starve_ar1", last_a_ready, 1'b1);
    applyStimulus(1'b1, 4'd1, 32'h3, 1'b0, '0, '0);
    checkOutput("starve_ar2", last_a_ready, 1'b1);
    applyStimulus(1'b1, 4'd1, 32'h4, 1'b0, '0, '0);
    checkOutput("starve_ar3", last_a_ready, 1'b1);
    applyStimulus(1'b1, 4'd1, 32'h5, 1'b0, '0, '0);
    checkOutput("starve_ar4", last_a_ready, 1'b0);
    applyStimulus(1'b1, 4'd1, 32'h5, 1'b0, '0, '0);
    checkOutput("starve_ar5", last_a_ready, 1'b1);
    checkOutput("starve_waddr", last_waddr, 4'd2);
    checkOutput("starve_wdata", last_wdata, 32'h22);
    idleCycles(2);

    // Hazard: a queued write to r7 must reach the register file before A's write to r7.
    applyStimulus(1'b0, '0, '0, 1'b1, 4'd7, 32'h77);
    applyStimulus(1'b1, 4'd7, 32'h99, 1'b0, '0, '0);
    checkOutput("hazard_ar0", last_a_ready, 1'b0);
    checkOutput("hazard_pend", last_pend, 16'h0080);
    applyStimulus(1'b1, 4'd7, 32'h99, 1'b0, '0, '0);
    checkOutput("hazard_ar1", last_a_ready, 1'b1);
    checkOutput("hazard_first", last_wdata, 32'h77);
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0);
    checkOutput("hazard_second", last_wdata, 32'h99);
    checkOutput("hazard_waddr", last_waddr, 4'd7);
    idleCycles(2);

    // Full FIFO: A hogs while four entries are pushed; the fifth push is held off.
    applyStimulus(1'b1, 4'd1, 32'hA0, 1'b1, 4'd8,  32'h80);
    applyStimulus(1'b1, 4'd1, 32'hA1, 1'b1, 4'd9,  32'h90);
    applyStimulus(1'b1, 4'd1, 32'hA2, 1'b1, 4'd10, 32'hA0);
    applyStimulus(1'b1, 4'd1, 32'hA3, 1'b1, 4'd11, 32'hB0);
    applyStimulus(1'b1, 4'd1, 32'hA4, 1'b1, 4'd12, 32'hC0);
    checkOutput("full_qcnt", last_q_count, 3'd4);
    checkOutput("full_bready", last_b_ready, 1'b0);
    checkOutput("full_pend", last_pend, 16'h0F00);
    idleCycles(6);
    checkOutput("full_drain", last_q_count, 3'd0);

    // Random traffic, first balanced, then A-heavy to exercise starvation and full.
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 2) != 0, AW'($urandom_range(0, 15)), $urandom);
    end
    for (int i = 0; i < 300; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, AW'($urandom_range(0, 15)), $urandom,
                    $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)), $urandom);
    end
    idleCycles(6);

    // Reset mid-operation: two entries queued and a write pending, then async reset.
    applyStimulus(1'b1, 4'd1, 32'h5A, 1'b1, 4'd4, 32'h44);
    applyStimulus(1'b1, 4'd2, 32'h5B, 1'b1, 4'd6, 32'h66);
    checkOutput("mid_qcnt_pre", q_count, 3'd2);
    checkOutput("mid_we_pre", rf_we, 1'b1);
    rst_n = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    checkOutput("mid_rst_we", rf_we, 1'b0);
    checkOutput("mid_rst_qcnt", q_count, 3'd0);
    checkOutput("mid_rst_pend", pend_mask, 16'h0);
    checkOutput("mid_rst_waddr", rf_waddr, 4'd0);
    modelReset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idleCycles(3);
    checkOutput("mid_no_stale", last_rf_we, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
